// File: rtl/evm_pkg.sv
// Shared types and helpers for the multi-candidate voting machine.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_CAND = 3'd1,
    ST_WAIT_VOTE = 3'd2,
    ST_VOTED     = 3'd3,
    ST_TALLY     = 3'd4,
    ST_DONE      = 3'd5
  } evm_state_t;

  // Index width for candidates 1..n with 0 reserved for "none".
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/evm_tally.sv
// Sequential max/tie scan over the candidate counters, one candidate per cycle.
module evm_tally
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int WIDTH    = 8,
  parameter int IDXW     = idx_width(NUM_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      start,
  input  logic [NUM_CAND*WIDTH-1:0] counts,
  output logic [IDXW-1:0]           winner,
  output logic [WIDTH-1:0]          max_count,
  output logic                      tie,
  output logic                      done
);

  logic                 active_reg;
  logic [IDXW-1:0]      idx_reg;
  logic [WIDTH-1:0]     max_reg;
  logic [IDXW-1:0]      winner_reg;
  logic                 tie_reg;
  logic [WIDTH-1:0]     cur_count;

  always_comb begin
    cur_count = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (idx_reg == IDXW'(i + 1)) begin
        cur_count = counts[i*WIDTH +: WIDTH];
      end
    end
  end

  // High during the cycle whose closing edge scans the last candidate.
  assign done = active_reg && (idx_reg == IDXW'(NUM_CAND));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      active_reg <= 1'b0;
      idx_reg    <= '0;
      max_reg    <= '0;
      winner_reg <= '0;
      tie_reg    <= 1'b0;
    end else if (start) begin
      active_reg <= 1'b1;
      idx_reg    <= IDXW'(1);
      max_reg    <= '0;
      winner_reg <= '0;
      tie_reg    <= 1'b0;
    end else if (active_reg) begin
      // Candidate 1 seeds the running max; equal later counts only flag a tie.
      if ((idx_reg == IDXW'(1)) || (cur_count > max_reg)) begin
        max_reg    <= cur_count;
        winner_reg <= idx_reg;
        tie_reg    <= 1'b0;
      end else if (cur_count == max_reg) begin
        tie_reg <= 1'b1;
      end
      if (done) begin
        active_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + IDXW'(1);
      end
    end
  end

  assign winner    = winner_reg;
  assign max_count = max_reg;
  assign tie       = tie_reg;

endmodule

// File: rtl/multi_candidate_evm.sv
// Electronic voting machine: vote capture, saturating tallies, winner/tie display.
// Optional EVM_TOTAL_COUNT_EN adds total_votes and rejected_votes outputs.
module multi_candidate_evm
  import evm_pkg::*;
#(
  parameter int  NUM_CAND = 4,
  parameter int  WIDTH    = 8,
  localparam int IDXW     = idx_width(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                switch_on_evm,
  input  logic                candidate_ready,
  input  logic [NUM_CAND-1:0] vote,
  input  logic                voting_session_done,
  input  logic [IDXW-1:0]     display_sel,
  input  logic                display_winner,
  output logic                voting_in_progress,
  output logic                vote_accepted,
  output logic                vote_rejected,
  output logic                tally_busy,
  output logic                voting_done,
  output logic [IDXW-1:0]     candidate_name,
  output logic [WIDTH-1:0]    results,
  output logic                invalid_results
`ifdef EVM_TOTAL_COUNT_EN
  ,
  output logic [WIDTH+3:0]    total_votes,
  output logic [WIDTH-1:0]    rejected_votes
`endif
);

  evm_state_t                state_reg, state_next;
  logic                      vote_onehot, vote_sampled, vote_take, vote_drop;
  logic                      clear_counts, tally_start;
  logic                      accepted_reg, rejected_reg;
  logic [NUM_CAND*WIDTH-1:0] counts_flat;
  logic [IDXW-1:0]           tally_winner;
  logic [WIDTH-1:0]          tally_max;
  logic                      tally_tie, tally_done;

  assign vote_onehot  = (vote != '0) && ((vote & (vote - NUM_CAND'(1))) == '0);
  assign vote_sampled = switch_on_evm && (state_reg == ST_WAIT_VOTE) &&
                        !candidate_ready && (vote != '0);
  assign vote_take    = vote_sampled && vote_onehot;
  assign vote_drop    = vote_sampled && !vote_onehot;
  assign clear_counts = !switch_on_evm || (state_reg == ST_IDLE);
  assign tally_start  = switch_on_evm && (state_reg == ST_WAIT_CAND) &&
                        !candidate_ready && voting_session_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      state_next = ST_WAIT_CAND;
      ST_WAIT_CAND: begin
        if (candidate_ready)          state_next = ST_WAIT_VOTE;
        else if (voting_session_done) state_next = ST_TALLY;
      end
      ST_WAIT_VOTE: if (vote_take) state_next = ST_VOTED;
      ST_VOTED:     state_next = candidate_ready ? ST_WAIT_VOTE : ST_WAIT_CAND;
      ST_TALLY:     if (tally_done) state_next = ST_DONE;
      ST_DONE:      state_next = ST_DONE;
      default:      state_next = ST_IDLE;
    endcase
    if (!switch_on_evm) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      accepted_reg <= 1'b0;
      rejected_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      accepted_reg <= vote_take;
      rejected_reg <= vote_drop;
    end
  end

  // One saturating counter per candidate; a vote at saturation is still accepted.
  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cnt
    logic [WIDTH-1:0] count_reg;
    always_ff @(posedge clk) begin
      if (rst || clear_counts) begin
        count_reg <= '0;
      end else if (vote_take && vote[gi] && (count_reg != '1)) begin
        count_reg <= count_reg + WIDTH'(1);
      end
    end
    assign counts_flat[gi*WIDTH +: WIDTH] = count_reg;
  end

  evm_tally #(
    .NUM_CAND (NUM_CAND),
    .WIDTH    (WIDTH),
    .IDXW     (IDXW)
  ) u_tally (
    .clk       (clk),
    .rst       (rst),
    .clear     (!switch_on_evm),
    .start     (tally_start),
    .counts    (counts_flat),
    .winner    (tally_winner),
    .max_count (tally_max),
    .tie       (tally_tie),
    .done      (tally_done)
  );

  always_comb begin
    candidate_name = '0;
    results        = '0;
    if ((state_reg == ST_DONE) && !tally_tie) begin
      if (display_winner) begin
        candidate_name = tally_winner;
        results        = tally_max;
      end else begin
        for (int i = 0; i < NUM_CAND; i++) begin
          if (display_sel == IDXW'(i + 1)) begin
            candidate_name = display_sel;
            results        = counts_flat[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign voting_in_progress = (state_reg == ST_WAIT_VOTE);
  assign tally_busy         = (state_reg == ST_TALLY);
  assign voting_done        = (state_reg == ST_DONE);
  assign invalid_results    = (state_reg == ST_DONE) && tally_tie;
  assign vote_accepted      = accepted_reg;
  assign vote_rejected      = rejected_reg;

`ifdef EVM_TOTAL_COUNT_EN
  logic [WIDTH+3:0] total_reg;
  logic [WIDTH-1:0] rejected_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      total_reg        <= '0;
      rejected_cnt_reg <= '0;
    end else begin
      if (vote_take && (total_reg != '1)) total_reg <= total_reg + (WIDTH+4)'(1);
      if (vote_drop && (rejected_cnt_reg != '1)) rejected_cnt_reg <= rejected_cnt_reg + WIDTH'(1);
    end
  end

  assign total_votes    = total_reg;
  assign rejected_votes = rejected_cnt_reg;
`endif

endmodule

// File: tb/tb_multi_candidate_evm.sv
// Bench: two EVMs (WIDTH 8 and 2) on shared stimulus, checked each cycle against a phase/vote-count model.
module tb_multi_candidate_evm;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst, sw, cr, done_in, dwin;
  logic [3:0] vote;
  logic [2:0] dsel;

  logic       a_vip, a_acc, a_rej, a_busy, a_done, a_inv;
  logic [2:0] a_name;
  logic [7:0] a_res;
  logic       b_vip, b_acc, b_rej, b_busy, b_done, b_inv;
  logic [2:0] b_name;
  logic [1:0] b_res;
`ifdef EVM_TOTAL_COUNT_EN
  logic [11:0] a_total;
  logic [7:0]  a_rejv;
  logic [5:0]  b_total;
  logic [1:0]  b_rejv;
`endif

  always #5 clk = ~clk;

  multi_candidate_evm #(.NUM_CAND(NC), .WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .switch_on_evm(sw), .candidate_ready(cr), .vote(vote),
    .voting_session_done(done_in), .display_sel(dsel), .display_winner(dwin),
    .voting_in_progress(a_vip), .vote_accepted(a_acc), .vote_rejected(a_rej),
    .tally_busy(a_busy), .voting_done(a_done), .candidate_name(a_name),
    .results(a_res), .invalid_results(a_inv)
`ifdef EVM_TOTAL_COUNT_EN
    , .total_votes(a_total), .rejected_votes(a_rejv)
`endif
  );

  multi_candidate_evm #(.NUM_CAND(NC), .WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .switch_on_evm(sw), .candidate_ready(cr), .vote(vote),
    .voting_session_done(done_in), .display_sel(dsel), .display_winner(dwin),
    .voting_in_progress(b_vip), .vote_accepted(b_acc), .vote_rejected(b_rej),
    .tally_busy(b_busy), .voting_done(b_done), .candidate_name(b_name),
    .results(b_res), .invalid_results(b_inv)
`ifdef EVM_TOTAL_COUNT_EN
    , .total_votes(b_total), .rejected_votes(b_rejv)
`endif
  );

  int checks = 0;
  int failures = 0;
  int acc_b = 0;

  typedef enum int {M_IDLE, M_WCAND, M_WVOTE, M_VOTED, M_TALLY, M_DONE} mphase_t;
  mphase_t ph = M_IDLE;
  int      nv[NC];
  int      tcnt = 0;
  bit      exp_acc = 0, exp_rej = 0, model_valid = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected display outputs from the true vote counts, clipped to a counter width.
  task automatic exp_disp(input int w, output int en, output int er, output int ei);
    int mx, win, ncnt, s;
    en = 0; er = 0; ei = 0;
    if (ph != M_DONE) return;
    mx = -1; win = 0; ncnt = 0;
    for (int i = 0; i < NC; i++) begin
      s = sat(nv[i], w);
      if (s > mx) begin mx = s; win = i + 1; ncnt = 1; end
      else if (s == mx) ncnt++;
    end
    if (ncnt > 1) begin ei = 1; return; end
    if (dwin) begin en = win; er = mx; end
    else if (dsel >= 1 && dsel <= NC) begin en = int'(dsel); er = sat(nv[dsel - 1], w); end
  endtask

  task automatic cmp_dut(input string tag, input int w, input logic vip, input logic acc,
                         input logic rej, input logic busy, input logic dn,
                         input logic [2:0] name, input logic [7:0] res, input logic inv);
    int en, er, ei;
    exp_disp(w, en, er, ei);
    check({tag, "_in_progress"}, vip, ph == M_WVOTE);
    check({tag, "_accepted"}, acc, exp_acc);
    check({tag, "_rejected"}, rej, exp_rej);
    check({tag, "_tally_busy"}, busy, ph == M_TALLY);
    check({tag, "_voting_done"}, dn, ph == M_DONE);
    check({tag, "_name"}, name, en);
    check({tag, "_results"}, res, er);
    check({tag, "_invalid"}, inv, ei);
  endtask

  // Model: advances on each rising edge from the inputs held across it.
  initial begin
    for (int i = 0; i < NC; i++) nv[i] = 0;
    forever begin
      @(posedge clk);
      exp_acc = 0;
      exp_rej = 0;
      if (rst || !sw) begin
        if (rst) model_valid = 1;
        ph = M_IDLE;
        for (int i = 0; i < NC; i++) nv[i] = 0;
      end else begin
        case (ph)
          M_IDLE: begin
            ph = M_WCAND;
            for (int i = 0; i < NC; i++) nv[i] = 0;
          end
          M_WCAND: begin
            if (cr) ph = M_WVOTE;
            else if (done_in) begin ph = M_TALLY; tcnt = 0; end
          end
          M_WVOTE: begin
            if (!cr && vote != 0) begin
              if ($countones(vote) == 1) begin
                for (int i = 0; i < NC; i++) if (vote[i]) nv[i]++;
                exp_acc = 1;
                ph = M_VOTED;
              end else begin
                exp_rej = 1;
              end
            end
          end
          M_VOTED: ph = cr ? M_WVOTE : M_WCAND;
          M_TALLY: begin
            tcnt++;
            if (tcnt == NC) ph = M_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_valid) begin
        cmp_dut("w8", 8, a_vip, a_acc, a_rej, a_busy, a_done, a_name, a_res, a_inv);
        cmp_dut("w2", 2, b_vip, b_acc, b_rej, b_busy, b_done, b_name, {6'b0, b_res}, b_inv);
        if (b_acc === 1'b1) acc_b++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cast(input logic [3:0] v);
    $display("cast vote=%b", v);
    cr = 1; tick();
    cr = 0; vote = v; tick();
    vote = 0; tick();
  endtask

  task automatic close_poll();
    $display("close poll");
    done_in = 1; tick();
    done_in = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_done === 1'b1) break;
      tick();
    end
    check("reach_done", a_done, 1);
  endtask

  task automatic power_cycle();
    $display("power cycle");
    sw = 0; tick();
    sw = 1; tick();
  endtask

  initial begin
    rst = 1; sw = 0; cr = 0; vote = 0; done_in = 0; dsel = 0; dwin = 0;
    tick(); tick();
    check("rst_done", a_done, 0);
    check("rst_name", a_name, 0);
    rst = 0; sw = 1; tick();

    // Winner c2 with 3 votes; c4 entered via VOTED -> WAIT_VOTE path.
    repeat (3) cast(4'b0010);
    cast(4'b0001);
    $display("cast vote=1000 twice, voter held");
    cr = 1; tick();
    cr = 0; vote = 4'b1000; tick();
    cr = 1; tick();
    cr = 0; tick();
    vote = 0; tick();
    dwin = 1;
    close_poll();
    check("s1_name", a_name, 2);
    check("s1_results", a_res, 3);
    check("s1_invalid", a_inv, 0);
    dwin = 0; dsel = 4; tick();
    check("s1_sel4_name", a_name, 4);
    check("s1_sel4_results", a_res, 2);
    dsel = 5; tick();
    check("s1_sel5_name", a_name, 0);
    check("s1_sel5_results", a_res, 0);
    $display("vote attempt in DONE");
    cr = 1; tick();
    cr = 0; vote = 4'b0010; tick();
    vote = 0; dsel = 2; tick();
    check("s1_done_held", a_done, 1);
    check("s1_sel2_results", a_res, 3);

    // Tie between c1 and c3.
    power_cycle();
    repeat (2) cast(4'b0001);
    repeat (2) cast(4'b0100);
    dwin = 1;
    close_poll();
    check("s2_invalid", a_inv, 1);
    check("s2_name", a_name, 0);
    check("s2_results", a_res, 0);

    // Multi-hot rejection, then a valid vote.
    power_cycle();
    dwin = 0;
    $display("cast vote=0101 then 0100");
    cr = 1; tick();
    cr = 0; vote = 4'b0101; tick();
    check("s3_rejected", a_rej, 1);
    check("s3_still_waiting", a_vip, 1);
    vote = 4'b0100; tick();
    check("s3_accepted", a_acc, 1);
    vote = 0; tick();
    close_poll();
    dsel = 3; tick();
    check("s3_c3_name", a_name, 3);
    check("s3_c3_results", a_res, 1);

    // Saturation on the 2-bit instance.
    power_cycle();
    acc_b = 0;
    repeat (5) cast(4'b0001);
    check("s4_pulses_w2", acc_b, 5);
    close_poll();
    dsel = 1; tick();
    check("s4_c1_w2", b_res, 3);
    check("s4_c1_w8", a_res, 5);
    dwin = 1; tick();
    check("s4_winner_w2", b_name, 1);

    // Power drop mid-tally.
    power_cycle();
    cast(4'b0010);
    $display("drop power mid-tally");
    done_in = 1; tick();
    done_in = 0; tick();
    check("s5_busy", a_busy, 1);
    sw = 0; tick();
    check("s5_idle_busy", a_busy, 0);
    check("s5_idle_done", a_done, 0);
    sw = 1; tick();
    check("s5_wait_cand", a_vip, 0);
    close_poll();
    check("s5_all_zero_tie", a_inv, 1);
    dwin = 0;
    for (int s = 1; s <= NC; s++) begin
      dsel = 3'(s); tick();
      check("s5_count_zero", a_res, 0);
    end

    // Reset in DONE, then reset mid-tally.
    $display("reset in DONE");
    rst = 1; tick();
    check("s6_done", a_done, 0);
    check("s6_busy", a_busy, 0);
    check("s6_invalid", a_inv, 0);
    check("s6_name", a_name, 0);
    check("s6_results", a_res, 0);
    check("s6_accepted", a_acc, 0);
    rst = 0; tick();
    cast(4'b1000);
    $display("reset mid-tally");
    done_in = 1; tick();
    done_in = 0; rst = 1; tick();
    check("s6_tally_abort", a_busy, 0);
    rst = 0; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_candidate_evm.md
MULTI_CANDIDATE_EVM -- requirements
Module: multi_candidate_evm

Interface
REQ-001 SHALL take parameter NUM_CAND, default 4, range 2..15: number of candidates.
REQ-002 SHALL take parameter WIDTH, default 8: per-candidate vote-counter width.
REQ-003 SHALL derive constant IDXW = $clog2(NUM_CAND+1), the candidate-index width; index 0 means "none".
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 switch_on_evm  input  1  power enable; low forces power-off.
REQ-008 candidate_ready  input  1  voter present at booth.
REQ-009 vote  input  NUM_CAND  vote buttons; bit i selects candidate i+1.
REQ-010 voting_session_done  input  1  close the poll.
REQ-011 display_sel  input  IDXW  candidate to display, 1-based.
REQ-012 display_winner  input  1  show the winner instead of display_sel.
REQ-013 voting_in_progress  output  1  high in WAIT_VOTE.
REQ-014 vote_accepted  output  1  one-cycle pulse per counted vote.
REQ-015 vote_rejected  output  1  one-cycle pulse per malformed vote.
REQ-016 tally_busy  output  1  high in TALLY.
REQ-017 voting_done  output  1  high in DONE.
REQ-018 candidate_name  output  IDXW  displayed candidate index.
REQ-019 results  output  WIDTH  displayed vote count.
REQ-020 invalid_results  output  1  tie for highest count, in DONE only.

Function
REQ-021 States: IDLE, WAIT_CAND, WAIT_VOTE, VOTED, TALLY, DONE; all outputs SHALL be registered or decoded from registered state.
REQ-022 IDLE->WAIT_CAND when switch_on_evm=1; all counters clear on that transition.
REQ-023 WAIT_CAND: candidate_ready=1 -> WAIT_VOTE; else voting_session_done=1 -> TALLY; candidate_ready has priority.
REQ-024 WAIT_VOTE: a vote is sampled only when candidate_ready=0 and vote!=0.
REQ-025 One-hot vote -> VOTED; the selected counter increments at that edge; vote_accepted pulses the following cycle.
REQ-026 Multi-hot vote -> vote_rejected pulse the following cycle; no counter change; the FSM stays in WAIT_VOTE.
REQ-027 VOTED lasts exactly one cycle, then goes to WAIT_VOTE if candidate_ready=1, else to WAIT_CAND. Buttons held through VOTED SHALL NOT count again.
REQ-028 Counters SHALL saturate at 2^WIDTH-1; a vote at saturation is still accepted (pulse) but not counted.
REQ-029 TALLY scans one candidate per cycle, index 1..NUM_CAND, tracking maximum, winner index and tie flag; it lasts exactly NUM_CAND cycles, then goes to DONE.
REQ-030 Tie: a later count equal to the running max sets the tie flag; a strictly greater count clears it and updates the winner; the lowest index wins equal counts.
REQ-031 DONE: invalid_results = tie flag. If tie: candidate_name=0, results=0.
REQ-032 DONE, no tie, display_winner=1: candidate_name=winner, results=winner count.
REQ-033 DONE, no tie, display_winner=0: display_sel in 1..NUM_CAND shows that candidate; otherwise 0/0.
REQ-034 DONE persists while switch_on_evm=1; further votes are ignored.
REQ-035 switch_on_evm=0 in any state: next state IDLE, counters and tally registers clear, pulses suppressed.
REQ-036 Outside DONE: candidate_name=0, results=0, invalid_results=0.

Reset
REQ-037 rst=1 at a clock edge: state IDLE, all counters, flags and tally registers zero, every output 0; rst overrides switch_on_evm, including mid-TALLY.

Configuration
REQ-038 Macro EVM_TOTAL_COUNT_EN defined: add output total_votes (WIDTH+4 bits) = accepted-vote count, non-saturating below its own max, cleared like the counters, and add output rejected_votes (WIDTH bits), saturating.
REQ-039 Macro EVM_TOTAL_COUNT_EN undefined: neither port nor its logic exists; all other behaviour is identical.

Structure
REQ-040 Package evm_pkg SHALL hold the state enum and the idx_width(n) function used for IDXW.
REQ-041 Sub-module evm_tally SHALL implement the sequential max/tie scan (start, count vector in; winner, max, tie, done out).

Verification
REQ-042 NUM_CAND=4, WIDTH=8; votes c2 x3, c1 x1, c4 x2; close -> after 4 tally cycles, display_winner=1 gives name=2, results=3, invalid=0.
REQ-043 Votes c1 x2, c3 x2; close -> invalid_results=1, name=0, results=0.
REQ-044 vote=4'b0101 in WAIT_VOTE -> vote_rejected pulse, counts unchanged, still WAIT_VOTE; then 4'b0100 -> c3=1.
REQ-045 WIDTH=2; 5 votes for c1 -> c1 reads 3, five vote_accepted pulses.
REQ-046 switch_on_evm dropped mid-TALLY, then raised -> IDLE, then WAIT_CAND, all counts read 0 after a fresh close.
REQ-047 rst pulsed in DONE -> next cycle IDLE, all outputs 0.
